// File: rtl/processor_pkg.sv
// rtl/processor_pkg.sv - shared state encoding, opcodes and defaults for the Z processor control path
package processor_pkg;

    localparam int DEFAULT_ADDR_W = 9;
    localparam int DEFAULT_DATA_W = 32;
    localparam int PIPE_DEPTH     = 4;

    localparam logic [3:0] OP_IRMOV = 4'h1;
    localparam logic [3:0] OP_ADD   = 4'h2;
    localparam logic [3:0] OP_SUB   = 4'h3;
    localparam logic [3:0] OP_AND   = 4'h4;
    localparam logic [3:0] OP_XOR   = 4'h5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_DONE
    } run_state_t;

endpackage

// File: rtl/run_controller.sv
// rtl/run_controller.sv - boot/run sequencer owning the instruction-RAM port and pipeline enables
module run_controller
    import processor_pkg::*;
#(
    parameter int ADDR_W       = DEFAULT_ADDR_W,
    parameter int DATA_W       = DEFAULT_DATA_W,
    parameter int RST_CYCLES   = 2,
    parameter int DRAIN_CYCLES = PIPE_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [DATA_W-1:0] host_data,
    input  logic              host_last,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              working,
    output logic              reg_rst,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W:0]   prog_len,
    output logic [15:0]       cycle_count,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    run_state_t        state;
    logic [ADDR_W:0]   load_ptr;
    logic [ADDR_W:0]   prog_len_q;
    logic [ADDR_W-1:0] pc_q;
    logic [15:0]       cycle_q;
    logic [15:0]       timer;
    logic              err_q;

    logic              accept;
    logic [ADDR_W:0]   wr_base;
    logic [ADDR_W:0]   wr_next;
    logic              pc_last;

    assign host_ready = (state inside {S_IDLE, S_LOAD, S_DONE}) && (load_ptr < DEPTH);
    assign accept     = host_valid && host_ready;
    // a beat arriving outside LOAD begins a fresh program at address 0
    assign wr_base    = (state == S_LOAD) ? load_ptr : '0;
    assign wr_next    = wr_base + 1'b1;
    assign pc_last    = ({1'b0, pc_q} == (prog_len_q - 1'b1));

    always_comb begin
        mem_addr  = '0;
        mem_wr    = 1'b0;
        mem_wdata = '0;
        mem_rd    = 1'b0;
        if (accept) begin
            mem_wr    = 1'b1;
            mem_addr  = wr_base[ADDR_W-1:0];
            mem_wdata = host_data;
        end else if (state == S_RUN) begin
            mem_rd   = 1'b1;
            mem_addr = pc_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= S_IDLE;
            load_ptr   <= '0;
            prog_len_q <= '0;
            pc_q       <= '0;
            cycle_q    <= '0;
            timer      <= '0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if ((state inside {S_CLEAR, S_RUN, S_DRAIN}) && (cycle_q != 16'hFFFF)) begin
                cycle_q <= cycle_q + 16'd1;
            end
            if (accept) begin
                load_ptr   <= wr_next;
                prog_len_q <= wr_next;
                if (abort || host_last || (wr_next == DEPTH)) begin
                    state <= S_IDLE;
                end else begin
                    state <= S_LOAD;
                end
            end else if (abort && (state != S_IDLE)) begin
                state <= S_IDLE;
                timer <= '0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            if (prog_len_q == '0) begin
                                err_q <= 1'b1;
                            end else begin
                                state   <= S_CLEAR;
                                pc_q    <= '0;
                                cycle_q <= '0;
                                timer   <= '0;
                            end
                        end
                    end
                    S_CLEAR: begin
                        if (timer == 16'(RST_CYCLES - 1)) begin
                            timer <= '0;
                            state <= S_RUN;
                        end else begin
                            timer <= timer + 16'd1;
                        end
                    end
                    S_RUN: begin
                        // pc parks on the last fetch address so a full-depth program never wraps
                        if (pc_last) begin
                            state <= S_DRAIN;
                        end else begin
                            pc_q <= pc_q + 1'b1;
                        end
                    end
                    S_DRAIN: begin
                        if (timer == 16'(DRAIN_CYCLES - 1)) begin
                            timer <= '0;
                            state <= S_DONE;
                        end else begin
                            timer <= timer + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign working     = (state == S_RUN) || (state == S_DRAIN);
    assign reg_rst     = (state == S_CLEAR);
    assign done        = (state == S_DONE);
    assign busy        = state inside {S_LOAD, S_CLEAR, S_RUN, S_DRAIN};
    assign err         = err_q;
    assign pc          = pc_q;
    assign prog_len    = prog_len_q;
    assign cycle_count = cycle_q;

endmodule
